alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 48 ++++
 rtl/alu_issue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Instruction fetch, register-file read, ALU issue and result
//               return signals for the alu_issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_control;
    logic [3:0]  rd;
    logic        wb_en;
    logic        is_cmp;
    logic        res_valid;
    logic        res_cmp;
    logic [31:0] result;
    logic        flags_e;
    logic        flags_gt;
    logic        illegal;
    logic [15:0] issue_count;

    // Issue stage side
    modport slave (
        input  in_valid, instr, rf_data1, rf_data2, out_ready,
               res_valid, res_cmp, result,
        output in_ready, rf_addr1, rf_addr2, out_valid, a, b, alu_control,
               rd, wb_en, is_cmp, flags_e, flags_gt, illegal, issue_count
    );

    // Surrounding pipeline side
    modport master (
        output in_valid, instr, rf_data1, rf_data2, out_ready,
               res_valid, res_cmp, result,
        input  in_ready, rf_addr1, rf_addr2, out_valid, a, b, alu_control,
               rd, wb_en, is_cmp, flags_e, flags_gt, illegal, issue_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Decodes one instruction per cycle, forms ALU operands and
//               holds the issued op in a single-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter logic [4:0] ILL_CODE = 5'b11111
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_issue_if.slave bus
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [4:0] c_OP_CMP = 5'd5;
    localparam logic [4:0] c_OP_NOT = 5'd8;
    localparam logic [4:0] c_OP_MOV = 5'd9;
    localparam logic [4:0] c_OP_LSL = 5'd10;
    localparam logic [4:0] c_OP_LSR = 5'd11;
    localparam logic [4:0] c_OP_ASR = 5'd12;
    localparam logic [4:0] c_OP_NOP = 5'd13;
    localparam logic [4:0] c_OP_LD  = 5'd14;
    localparam logic [4:0] c_OP_ST  = 5'd15;
    localparam logic [4:0] c_OP_RET = 5'd20;

    // Instruction fields
    logic [4:0]  w_opcode;
    logic        w_imm_sel;
    logic [3:0]  w_rd;
    logic [17:0] w_imm;
    logic [1:0]  w_mod;
    logic [31:0] w_imm_ext;
    logic [31:0] w_op2;
    logic        w_bad_mod;

    // Decoded op
    logic        w_issue;
    logic        w_illegal;
    logic [4:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_wb;
    logic        w_cmp;

    logic        w_accept;
    logic        w_load;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_ctrl;
    logic [3:0]  r_rd;
    logic        r_wb;
    logic        r_cmp;
    logic        r_flags_e;
    logic        r_flags_gt;
    logic        r_illegal;
    logic [15:0] r_count;

    assign w_opcode  = bus.instr[31:27];
    assign w_imm_sel = bus.instr[26];
    assign w_rd      = bus.instr[25:22];
    assign w_imm     = bus.instr[17:0];
    assign w_mod     = w_imm[17:16];
    assign w_bad_mod = w_imm_sel && (w_mod == 2'b11);

    assign bus.rf_addr1 = bus.instr[21:18];
    assign bus.rf_addr2 = bus.instr[17:14];

    always_comb begin
        w_imm_ext = 32'h0;
        case (w_mod)
            2'b00:   w_imm_ext = {{16{w_imm[15]}}, w_imm[15:0]};
            2'b01:   w_imm_ext = {16'h0, w_imm[15:0]};
            2'b10:   w_imm_ext = {w_imm[15:0], 16'h0};
            default: w_imm_ext = 32'h0;
        endcase
    end

    assign w_op2 = w_imm_sel ? w_imm_ext : bus.rf_data2;

    // Opcodes 13 and 16..20 fall through with neither issue nor illegal set,
    // so they are consumed silently.
    always_comb begin
        w_issue   = 1'b0;
        w_illegal = 1'b0;
        w_ctrl    = ILL_CODE;
        w_a       = 32'h0;
        w_b       = w_op2;
        w_wb      = 1'b0;
        w_cmp     = 1'b0;
        if (w_bad_mod || (w_opcode > c_OP_RET)) begin
            w_illegal = 1'b1;
        end else if (w_opcode <= 5'd7) begin
            w_issue = 1'b1;
            w_ctrl  = w_opcode;
            w_a     = bus.rf_data1;
            w_wb    = (w_opcode != c_OP_CMP);
            w_cmp   = (w_opcode == c_OP_CMP);
        end else begin
            case (w_opcode)
                c_OP_NOT: begin
                    w_issue = 1'b1;
                    w_ctrl  = 5'd8;
                    w_a     = w_op2;
                    w_b     = 32'h0;
                    w_wb    = 1'b1;
                end
                c_OP_MOV: begin
                    w_issue = 1'b1;
                    w_ctrl  = 5'd0;
                    w_wb    = 1'b1;
                end
                c_OP_LSL, c_OP_LSR, c_OP_ASR: begin
                    w_issue = 1'b1;
                    w_ctrl  = w_opcode - 5'd1;
                    w_a     = bus.rf_data1;
                    w_wb    = 1'b1;
                end
                c_OP_LD, c_OP_ST: begin
                    w_issue = 1'b1;
                    w_ctrl  = 5'd0;
                    w_a     = bus.rf_data1;
                    w_wb    = (w_opcode == c_OP_LD);
                end
                c_OP_NOP: w_issue = 1'b0;
                default:  w_issue = 1'b0;
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_EMPTY) || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_load       = w_accept && w_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_a        <= 32'h0;
            r_b        <= 32'h0;
            r_ctrl     <= ILL_CODE;
            r_rd       <= 4'h0;
            r_wb       <= 1'b0;
            r_cmp      <= 1'b0;
            r_flags_e  <= 1'b0;
            r_flags_gt <= 1'b0;
            r_illegal  <= 1'b0;
            r_count    <= 16'h0;
        end else begin
            r_illegal <= w_accept && w_illegal;

            if (bus.res_valid && bus.res_cmp) begin
                r_flags_e  <= (bus.result == 32'd0);
                r_flags_gt <= (bus.result == 32'd1);
            end

            if (w_load) begin
                r_count <= r_count + 16'd1;
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_load) begin
                        r_state <= S_FULL;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_ctrl  <= w_ctrl;
                        r_rd    <= w_rd;
                        r_wb    <= w_wb;
                        r_cmp   <= w_cmp;
                    end
                end
                S_FULL: begin
                    // Without out_ready the held op stays frozen.
                    if (bus.out_ready) begin
                        if (w_load) begin
                            r_a    <= w_a;
                            r_b    <= w_b;
                            r_ctrl <= w_ctrl;
                            r_rd   <= w_rd;
                            r_wb   <= w_wb;
                            r_cmp  <= w_cmp;
                        end else begin
                            r_state <= S_EMPTY;
                            r_a     <= 32'h0;
                            r_b     <= 32'h0;
                            r_ctrl  <= ILL_CODE;
                            r_rd    <= 4'h0;
                            r_wb    <= 1'b0;
                            r_cmp   <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.out_valid   = (r_state == S_FULL);
    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.alu_control = r_ctrl;
    assign bus.rd          = r_rd;
    assign bus.wb_en       = r_wb;
    assign bus.is_cmp      = r_cmp;
    assign bus.flags_e     = r_flags_e;
    assign bus.flags_gt    = r_flags_gt;
    assign bus.illegal     = r_illegal;
    assign bus.issue_count = r_count;

endmodule
`default_nettype wire
